// File: rtl/gate_pkg.sv
// Shared definitions for the logic_gates built-in self-test: gate bit
// positions, checker state encoding and the reference gate function.
package gate_pkg;

  localparam int NUM_GATES = 7;
  localparam int GATE_NOT  = 0;
  localparam int GATE_AND  = 1;
  localparam int GATE_OR   = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_NOR  = 4;
  localparam int GATE_XOR  = 5;
  localparam int GATE_XNOR = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Expected outputs of a healthy logic_gates unit for operands a and b.
  function automatic logic [NUM_GATES-1:0] expected_gates(input logic a, input logic b);
    logic [NUM_GATES-1:0] r;
    r            = 7'b000_0000;
    r[GATE_NOT]  = ~a;
    r[GATE_AND]  = a & b;
    r[GATE_OR]   = a | b;
    r[GATE_NAND] = ~(a & b);
    r[GATE_NOR]  = ~(a | b);
    r[GATE_XOR]  = a ^ b;
    r[GATE_XNOR] = ~(a ^ b);
    return r;
  endfunction

  // Number of set bits in a gate vector (at most 7, fits in 3 bits).
  function automatic logic [2:0] popcount7(input logic [NUM_GATES-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_GATES; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference for the two-input logic_gates unit.
module gate_ref_model
  import gate_pkg::*;
(
  input  logic                 a,
  input  logic                 b,
  output logic [NUM_GATES-1:0] expected
);

  assign expected = expected_gates(a, b);

endmodule

// File: rtl/gate_bist_checker.sv
// Built-in self-test for logic_gates: walks a/b through 00,01,10,11, lets
// each vector settle, then compares the unit's seven outputs against the
// reference model and accumulates sticky fail masks and a saturating count.
module gate_bist_checker
  import gate_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 a_o,
  output logic                 b_o,
  input  logic                 not_a_i,
  input  logic                 and_i,
  input  logic                 or_i,
  input  logic                 nand_i,
  input  logic                 nor_i,
  input  logic                 xor_i,
  input  logic                 xnor_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [NUM_GATES-1:0] fail_gate,
  output logic [3:0]           fail_vec,
  output logic [ERR_W-1:0]     err_count
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("gate_bist_checker: SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = {ERR_W{1'b1}};

  state_t               state_r;
  logic [1:0]           index_r;
  logic [3:0]           settle_r;

  logic [NUM_GATES-1:0] expected_s;
  logic [NUM_GATES-1:0] actual_s;
  logic [NUM_GATES-1:0] mismatch_s;
  logic [NUM_GATES-1:0] fail_gate_next_s;
  logic [2:0]           mismatch_cnt_s;
  logic [ERR_W+2:0]     err_sum_s;
  logic [ERR_W-1:0]     err_next_s;
  logic [1:0]           index_next_s;

  gate_ref_model u_ref (
    .a        (a_o),
    .b        (b_o),
    .expected (expected_s)
  );

  assign actual_s = {xnor_i, xor_i, nor_i, nand_i, or_i, and_i, not_a_i};

  // Per-vector comparison results and the saturating error count update.
  always_comb begin
    mismatch_s       = actual_s ^ expected_s;
    fail_gate_next_s = fail_gate | mismatch_s;
    mismatch_cnt_s   = popcount7(mismatch_s);
    err_sum_s        = {3'b000, err_count} + {{ERR_W{1'b0}}, mismatch_cnt_s};
    index_next_s     = index_r + 2'd1;
    if (err_sum_s > {3'b000, ERR_MAX}) begin
      err_next_s = ERR_MAX;
    end else begin
      err_next_s = err_sum_s[ERR_W-1:0];
    end
  end

  // Test sequencer with registered stimulus, status and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      index_r   <= 2'd0;
      settle_r  <= 4'd0;
      a_o       <= 1'b0;
      b_o       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_gate <= 7'b000_0000;
      fail_vec  <= 4'b0000;
      err_count <= {ERR_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          a_o  <= 1'b0;
          b_o  <= 1'b0;
          done <= 1'b0;
          if (start) begin
            state_r   <= ST_DRIVE;
            index_r   <= 2'd0;
            settle_r  <= 4'd0;
            busy      <= 1'b1;
            pass      <= 1'b0;
            fail_gate <= 7'b000_0000;
            fail_vec  <= 4'b0000;
            err_count <= {ERR_W{1'b0}};
          end else begin
            busy <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (settle_r == SETTLE_LAST) begin
            state_r  <= ST_CHECK;
            settle_r <= 4'd0;
          end else begin
            settle_r <= settle_r + 4'd1;
          end
        end
        ST_CHECK: begin
          fail_gate         <= fail_gate_next_s;
          fail_vec[index_r] <= |mismatch_s;
          err_count         <= err_next_s;
          if (index_r == 2'd3) begin
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= (err_next_s == {ERR_W{1'b0}}) && (fail_gate_next_s == 7'b000_0000);
            a_o     <= 1'b0;
            b_o     <= 1'b0;
          end else begin
            state_r <= ST_DRIVE;
            index_r <= index_next_s;
            a_o     <= index_next_s[1];
            b_o     <= index_next_s[0];
          end
        end
        ST_DONE: begin
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          a_o     <= 1'b0;
          b_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed self-checking bench for gate_bist_checker with an emulated
// logic_gates unit that can inject stuck-at and swap faults.
module tb_gate_bist_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  int         fault = 0;

  logic       a_o, b_o, busy, done, pass;
  logic [6:0] fail_gate;
  logic [3:0] fail_vec;
  logic [4:0] err_count;
  logic       not_a_i, and_i, or_i, nand_i, nor_i, xor_i, xnor_i;

  logic       a3, b3, busy3, done3, pass3;
  logic [6:0] fail_gate3;
  logic [3:0] fail_vec3;
  logic [2:0] err_count3;

  int n_cmp  = 0;
  int n_mism = 0;

  int   busy_n, done_n, done_at, done_at2, done_seen;
  logic pass_at_done;
  logic [1:0] ab_at10;

  always #5 clk = ~clk;

  // Emulated logic_gates unit; fault 1 = AND stuck at 0, fault 2 = XOR/XNOR swapped.
  assign not_a_i = ~a_o;
  assign and_i   = (fault == 1) ? 1'b0 : (a_o & b_o);
  assign or_i    = a_o | b_o;
  assign nand_i  = ~(a_o & b_o);
  assign nor_i   = ~(a_o | b_o);
  assign xor_i   = (fault == 2) ? ~(a_o ^ b_o) : (a_o ^ b_o);
  assign xnor_i  = (fault == 2) ? (a_o ^ b_o) : ~(a_o ^ b_o);

  gate_bist_checker dut (
    .clk(clk), .rst(rst), .start(start), .a_o(a_o), .b_o(b_o),
    .not_a_i(not_a_i), .and_i(and_i), .or_i(or_i), .nand_i(nand_i),
    .nor_i(nor_i), .xor_i(xor_i), .xnor_i(xnor_i),
    .busy(busy), .done(done), .pass(pass), .fail_gate(fail_gate),
    .fail_vec(fail_vec), .err_count(err_count)
  );

  // Second instance: every unit output stuck at 0, narrow saturating counter.
  gate_bist_checker #(.SETTLE_CYCLES(2), .ERR_W(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .a_o(a3), .b_o(b3),
    .not_a_i(1'b0), .and_i(1'b0), .or_i(1'b0), .nand_i(1'b0),
    .nor_i(1'b0), .xor_i(1'b0), .xnor_i(1'b0),
    .busy(busy3), .done(done3), .pass(pass3), .fail_gate(fail_gate3),
    .fail_vec(fail_vec3), .err_count(err_count3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start, then observe 30 cycles; optionally hold start or re-pulse it.
  task automatic run_obs(input bit hold, input int repulse_k);
    @(negedge clk);
    start = 1'b1;
    busy_n = 0; done_n = 0; done_at = 0; done_at2 = 0;
    pass_at_done = 1'b0; ab_at10 = 2'b00;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (k == 10) ab_at10 = {a_o, b_o};
      if (done) begin
        done_n++;
        if (done_n == 1) begin
          done_at = k;
          pass_at_done = pass;
        end else begin
          done_at2 = k;
        end
      end
      start = hold || (k == repulse_k);
    end
    start = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_a", a_o, 1'b0);
    check("rst_b", b_o, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_gate", fail_gate, 7'b000_0000);
    check("rst_vec", fail_vec, 4'b0000);
    check("rst_err", err_count, 5'd0);
    rst = 1'b0;

    // Healthy unit, default parameters
    fault = 0;
    run_obs(1'b0, 0);
    check("ok_busy_cycles", busy_n, 12);
    check("ok_done_count", done_n, 1);
    check("ok_done_at", done_at, 13);
    check("ok_pass_at_done", pass_at_done, 1'b1);
    check("ok_ab_vec3", ab_at10, 2'b11);
    check("ok_pass_hold", pass, 1'b1);
    check("ok_err", err_count, 5'd0);
    check("ok_gate", fail_gate, 7'b000_0000);
    check("ok_vec", fail_vec, 4'b0000);
    check("ok_ab_idle", {a_o, b_o}, 2'b00);

    // All-zero unit on ERR_W=3 instance: saturation
    check("sat_err", err_count3, 3'd7);
    check("sat_vec", fail_vec3, 4'b1111);
    check("sat_gate", fail_gate3, 7'b111_1111);
    check("sat_pass", pass3, 1'b0);

    // AND stuck at 0
    fault = 1;
    run_obs(1'b0, 0);
    check("and0_pass", pass, 1'b0);
    check("and0_gate", fail_gate, 7'b000_0010);
    check("and0_vec", fail_vec, 4'b1000);
    check("and0_err", err_count, 5'd1);

    // XOR/XNOR swapped, start re-pulsed while busy
    fault = 2;
    run_obs(1'b0, 5);
    check("swap_done_count", done_n, 1);
    check("swap_done_at", done_at, 13);
    check("swap_pass", pass, 1'b0);
    check("swap_gate", fail_gate, 7'b110_0000);
    check("swap_vec", fail_vec, 4'b1111);
    check("swap_err", err_count, 5'd8);

    // Healthy run clears the sticky results; start during DONE is ignored
    fault = 0;
    run_obs(1'b0, 13);
    check("clr_done_count", done_n, 1);
    check("clr_pass", pass, 1'b1);
    check("clr_gate", fail_gate, 7'b000_0000);
    check("clr_vec", fail_vec, 4'b0000);
    check("clr_err", err_count, 5'd0);

    // start held high: next run begins on the first IDLE cycle after DONE
    run_obs(1'b1, 0);
    check("hold_done_at", done_at, 13);
    check("hold_done_at2", done_at2, 27);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // rst during the second DRIVE, together with start
    fault = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_err_pre", err_count, 5'd2);
    check("mid_vec_pre", fail_vec, 4'b0001);
    check("mid_ab_pre", {a_o, b_o}, 2'b01);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("mid_busy", busy, 1'b0);
    check("mid_ab", {a_o, b_o}, 2'b00);
    check("mid_err", err_count, 5'd0);
    check("mid_vec", fail_vec, 4'b0000);
    check("mid_gate", fail_gate, 7'b000_0000);
    check("mid_pass", pass, 1'b0);
    done_seen = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("mid_no_done", done_seen, 0);

    // Fresh run after reset completes normally
    fault = 0;
    run_obs(1'b0, 0);
    check("fresh_done_at", done_at, 13);
    check("fresh_pass", pass_at_done, 1'b1);
    check("fresh_err", err_count, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
    $finish;
  end

endmodule
